// File: rtl/spi_packet_scheduler.sv
// Round-robin scheduler sharing one packet disassembler between nreqs requesters.
// Holds each grant until the disassembler has emitted every beat of the packet.
module spi_packet_scheduler #(
  parameter  int nreqs     = 2,
  parameter  int nbits_in  = 16,
  parameter  int nbits_out = 8,
  localparam int num_beats = (nbits_in + nbits_out - 1) / nbits_out,
  localparam int src_bits  = (nreqs > 1) ? $clog2(nreqs) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nreqs-1:0]          req_val,
  output logic [nreqs-1:0]          req_rdy,
  input  logic [nreqs*nbits_in-1:0] req_msg,
  output logic                      dis_req_val,
  input  logic                      dis_req_rdy,
  output logic [nbits_in-1:0]       dis_req_msg,
  input  logic                      dis_resp_val,
  input  logic                      dis_resp_rdy,
  output logic [src_bits-1:0]       cur_src,
  output logic                      busy,
  output logic                      done
);

  localparam int cnt_bits = $clog2(num_beats) + 1;

  localparam logic [1:0] state_idle  = 2'd0;
  localparam logic [1:0] state_send  = 2'd1;
  localparam logic [1:0] state_drain = 2'd2;

  localparam logic [src_bits:0]   nreqs_w  = (src_bits+1)'(nreqs);
  localparam logic [cnt_bits-1:0] last_cnt = cnt_bits'(num_beats - 1);

  logic [1:0]          state;
  logic [src_bits-1:0] ptr;
  logic [cnt_bits-1:0] beat_cnt;
  logic [nbits_in-1:0] msg_reg;
  logic [src_bits-1:0] src_reg;

  logic [2*nreqs-1:0]  req_dbl;
  logic [nreqs-1:0]    req_rot;
  logic                found;
  logic [src_bits-1:0] offset;
  logic [src_bits:0]   win_sum;
  logic [src_bits-1:0] winner;
  logic [src_bits:0]   ptr_sum;
  logic [src_bits-1:0] ptr_next;
  logic [nreqs-1:0]    grant_vec;
  logic [nbits_in-1:0] sel_msg;
  logic                beat;
  logic                last_beat;
  logic                accept;

  // Rotate requests so bit 0 is the ptr slot; the lowest set bit is the winner.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    req_dbl = {req_val, req_val} >> ptr;
    req_rot = req_dbl[nreqs-1:0];
    found   = 1'b0;
    offset  = '0;
    for (int k = nreqs - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found  = 1'b1;
        offset = src_bits'(k);
      end
    end
    win_sum = {1'b0, ptr} + {1'b0, offset};
    if (win_sum >= nreqs_w) win_sum = win_sum - nreqs_w;
    winner = win_sum[src_bits-1:0];

    ptr_sum  = {1'b0, winner} + (src_bits+1)'(1);
    ptr_next = (ptr_sum == nreqs_w) ? '0 : ptr_sum[src_bits-1:0];

    grant_vec = found ? (nreqs'(1) << winner) : '0;

    sel_msg = '0;
    for (int i = 0; i < nreqs; i++) begin
      if (winner == src_bits'(i)) sel_msg = req_msg[i*nbits_in +: nbits_in];
    end
  end

  // Grant is suppressed while reset is held so req_rdy drops immediately.
  assign req_rdy   = (state == state_idle && !reset) ? grant_vec : '0;
  assign accept    = (state == state_idle) && found;
  assign beat      = dis_resp_val & dis_resp_rdy;
  assign last_beat = beat_cnt == last_cnt;
  assign done      = beat && (state == state_drain) && last_beat;

  assign dis_req_val = state == state_send;
  assign dis_req_msg = msg_reg;
  assign busy        = state != state_idle;
  assign cur_src     = src_reg;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= state_idle;
      ptr      <= '0;
      beat_cnt <= '0;
      msg_reg  <= '0;
      src_reg  <= '0;
    end else begin
      case (state)
        state_idle: begin
          if (accept) begin
            msg_reg <= sel_msg;
            src_reg <= winner;
            ptr     <= ptr_next;
            state   <= state_send;
          end
        end
        state_send: begin
          if (dis_req_rdy) begin
            beat_cnt <= '0;
            state    <= state_drain;
          end
        end
        state_drain: begin
          if (beat) begin
            beat_cnt <= beat_cnt + cnt_bits'(1);
            if (last_beat) state <= state_idle;
          end
        end
        default: state <= state_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_packet_scheduler.sv
// Directed bench for spi_packet_scheduler: a 2-requester and a 3-requester
// instance, 16-bit packets into 8-bit beats (two beats per packet).
module tb_spi_packet_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Two-requester instance
  logic [1:0]  req_val2, req_rdy2;
  logic [31:0] req_msg2;
  logic        dis_req_val2, dis_req_rdy2, dis_resp_val2, dis_resp_rdy2;
  logic [15:0] dis_req_msg2;
  logic [0:0]  cur_src2;
  logic        busy2, done2;

  // Three-requester instance
  logic [2:0]  req_val3, req_rdy3;
  logic [47:0] req_msg3;
  logic        dis_req_val3, dis_req_rdy3, dis_resp_val3, dis_resp_rdy3;
  logic [15:0] dis_req_msg3;
  logic [1:0]  cur_src3;
  logic        busy3, done3;

  spi_packet_scheduler #(.nreqs(2), .nbits_in(16), .nbits_out(8)) dut2 (
    .clk(clk), .reset(reset),
    .req_val(req_val2), .req_rdy(req_rdy2), .req_msg(req_msg2),
    .dis_req_val(dis_req_val2), .dis_req_rdy(dis_req_rdy2), .dis_req_msg(dis_req_msg2),
    .dis_resp_val(dis_resp_val2), .dis_resp_rdy(dis_resp_rdy2),
    .cur_src(cur_src2), .busy(busy2), .done(done2)
  );

  spi_packet_scheduler #(.nreqs(3), .nbits_in(16), .nbits_out(8)) dut3 (
    .clk(clk), .reset(reset),
    .req_val(req_val3), .req_rdy(req_rdy3), .req_msg(req_msg3),
    .dis_req_val(dis_req_val3), .dis_req_rdy(dis_req_rdy3), .dis_req_msg(dis_req_msg3),
    .dis_resp_val(dis_resp_val3), .dis_resp_rdy(dis_resp_rdy3),
    .cur_src(cur_src3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_val2 = '0; req_msg2 = '0; dis_req_rdy2 = 1'b0; dis_resp_val2 = 1'b0; dis_resp_rdy2 = 1'b0;
    req_val3 = '0; req_msg3 = '0; dis_req_rdy3 = 1'b0; dis_resp_val3 = 1'b0; dis_resp_rdy3 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Serves one packet on dut2 starting from an IDLE cycle with req_val2 already set.
  task automatic serve2(input string tag, input int src, input logic [15:0] msg,
                        input logic [1:0] val_after);
    #1;
    check({tag, "_rdy"}, 32'(req_rdy2), 32'(1 << src));
    tick();
    req_val2 = val_after;
    dis_req_rdy2 = 1'b1;
    #1;
    check({tag, "_dval"}, 32'(dis_req_val2), 32'd1);
    check({tag, "_dmsg"}, 32'(dis_req_msg2), 32'(msg));
    check({tag, "_src"},  32'(cur_src2), 32'(src));
    tick();
    dis_req_rdy2 = 1'b0;
    dis_resp_val2 = 1'b1;
    dis_resp_rdy2 = 1'b1;
    #1;
    check({tag, "_done_b1"}, 32'(done2), 32'd0);
    tick();
    #1;
    check({tag, "_done_b2"}, 32'(done2), 32'd1);
    check({tag, "_src_b2"},  32'(cur_src2), 32'(src));
    tick();
    dis_resp_val2 = 1'b0;
    dis_resp_rdy2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single packet
    do_reset();
    #1;
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_dval", 32'(dis_req_val2), 32'd0);
    check("rst_dmsg", 32'(dis_req_msg2), 32'd0);
    check("rst_src",  32'(cur_src2), 32'd0);
    req_val2 = 2'b01;
    req_msg2 = {16'h0000, 16'hABCD};
    serve2("single", 0, 16'hABCD, 2'b00);
    #1;
    check("single_idle_busy", 32'(busy2), 32'd0);
    check("single_idle_src",  32'(cur_src2), 32'd0);

    // Simultaneous requests after reset
    do_reset();
    req_val2 = 2'b11;
    req_msg2 = {16'h2222, 16'h1111};
    serve2("simul0", 0, 16'h1111, 2'b10);
    serve2("simul1", 1, 16'h2222, 2'b00);
    #1;
    check("simul_hold_src", 32'(cur_src2), 32'd1);

    // Round-robin fairness, three requesters always valid
    do_reset();
    req_val3 = 3'b111;
    req_msg3 = {16'h3000, 16'h2000, 16'h1000};
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_rdy", 32'(req_rdy3), 32'(1 << (k % 3)));
      tick();
      dis_req_rdy3 = 1'b1;
      #1;
      check("rr_src",  32'(cur_src3), 32'(k % 3));
      check("rr_dmsg", 32'(dis_req_msg3), 32'(16'h1000 * ((k % 3) + 1)));
      tick();
      dis_req_rdy3 = 1'b0;
      dis_resp_val3 = 1'b1;
      dis_resp_rdy3 = 1'b1;
      #1;
      check("rr_done_b1", 32'(done3), 32'd0);
      tick();
      #1;
      check("rr_done_b2", 32'(done3), 32'd1);
      tick();
      dis_resp_val3 = 1'b0;
      dis_resp_rdy3 = 1'b0;
    end
    #1;
    check("rr_wrap", 32'(req_rdy3), 32'b001);

    // Backpressure on both disassembler ports, requester 0 pending meanwhile
    do_reset();
    req_val2 = 2'b10;
    req_msg2 = {16'hBEEF, 16'h5555};
    #1;
    check("bp_rdy", 32'(req_rdy2), 32'b10);
    tick();
    req_val2 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall_dval", 32'(dis_req_val2), 32'd1);
      check("bp_stall_dmsg", 32'(dis_req_msg2), 32'hBEEF);
      check("bp_stall_rdy",  32'(req_rdy2), 32'd0);
      tick();
    end
    dis_req_rdy2 = 1'b1;
    #1;
    check("bp_send_dmsg", 32'(dis_req_msg2), 32'hBEEF);
    tick();
    dis_req_rdy2 = 1'b0;
    dis_resp_val2 = 1'b1;
    dis_resp_rdy2 = 1'b1;
    #1;
    check("bp_done_b1", 32'(done2), 32'd0);
    check("bp_rdy_b1",  32'(req_rdy2), 32'd0);
    tick();
    dis_resp_rdy2 = 1'b0;
    #1;
    check("bp_done_stall", 32'(done2), 32'd0);
    check("bp_busy_stall", 32'(busy2), 32'd1);
    check("bp_rdy_stall",  32'(req_rdy2), 32'd0);
    tick();
    dis_resp_rdy2 = 1'b1;
    #1;
    check("bp_done_b2", 32'(done2), 32'd1);
    tick();
    dis_resp_val2 = 1'b0;
    dis_resp_rdy2 = 1'b0;
    #1;
    check("bp_next_rdy", 32'(req_rdy2), 32'b01);
    check("bp_idle_busy", 32'(busy2), 32'd0);

    // Spurious beats in IDLE and SEND
    do_reset();
    dis_resp_val2 = 1'b1;
    dis_resp_rdy2 = 1'b1;
    #1;
    check("spur_idle_done", 32'(done2), 32'd0);
    tick();
    req_val2 = 2'b01;
    req_msg2 = {16'h0000, 16'h1234};
    #1;
    check("spur_rdy", 32'(req_rdy2), 32'b01);
    check("spur_grant_done", 32'(done2), 32'd0);
    tick();
    req_val2 = 2'b00;
    dis_req_rdy2 = 1'b1;
    #1;
    check("spur_send_done", 32'(done2), 32'd0);
    check("spur_send_dmsg", 32'(dis_req_msg2), 32'h1234);
    tick();
    dis_req_rdy2 = 1'b0;
    #1;
    check("spur_done_b1", 32'(done2), 32'd0);
    tick();
    #1;
    check("spur_done_b2", 32'(done2), 32'd1);
    tick();
    dis_resp_val2 = 1'b0;
    dis_resp_rdy2 = 1'b0;

    // Reset in the middle of DRAIN with requester 1 pending
    do_reset();
    req_val2 = 2'b11;
    req_msg2 = {16'hCAFE, 16'h0BAD};
    #1;
    check("mid_rdy0", 32'(req_rdy2), 32'b01);
    tick();
    req_val2 = 2'b10;
    dis_req_rdy2 = 1'b1;
    tick();
    dis_req_rdy2 = 1'b0;
    dis_resp_val2 = 1'b1;
    dis_resp_rdy2 = 1'b1;
    #1;
    check("mid_done_b1", 32'(done2), 32'd0);
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_rdy",  32'(req_rdy2), 32'd0);
    check("mid_rst_busy", 32'(busy2), 32'd0);
    check("mid_rst_dval", 32'(dis_req_val2), 32'd0);
    check("mid_rst_dmsg", 32'(dis_req_msg2), 32'd0);
    check("mid_rst_src",  32'(cur_src2), 32'd0);
    check("mid_rst_done", 32'(done2), 32'd0);
    tick();
    reset = 1'b0;
    dis_resp_val2 = 1'b0;
    dis_resp_rdy2 = 1'b0;
    serve2("mid_after", 1, 16'hCAFE, 2'b00);
    #1;
    check("mid_no_replay_busy", 32'(busy2), 32'd0);
    check("mid_no_replay_rdy",  32'(req_rdy2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_packet_scheduler.md
# spi_packet_scheduler

Round-robin scheduler that shares a single packet disassembler between `nreqs` requesters in the SPI_v3 datapath. It accepts one wide packet from the winning requester, presents it to the disassembler's request port, and holds the grant until the disassembler has emitted every narrow output beat of that packet. It then re-arbitrates. It also exports the current packet's source id so downstream SPI logic can tag the beats.

## Interface
- `nreqs`, default 2: number of requesters (≥1).
- `nbits_in`, default 16: wide packet width, matching disassembler `nbits_in`.
- `nbits_out`, default 8: disassembler output beat width.
- `num_beats`, derived, not set: ceil(nbits_in/nbits_out).
- `src_bits`, derived, not set: max(1, $clog2(nreqs)).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_val`  in  nreqs  per-requester valid.
- `req_rdy`  out  nreqs  per-requester ready; at most one bit high.
- `req_msg`  in  nreqs×nbits_in  per-requester packet.
- `dis_req_val`  out  1  valid to disassembler request port.
- `dis_req_rdy`  in  1  ready from disassembler request port.
- `dis_req_msg`  out  nbits_in  packet to disassembler.
- `dis_resp_val`  in  1  snooped disassembler output valid.
- `dis_resp_rdy`  in  1  snooped downstream ready on disassembler output.
- `cur_src`  out  src_bits  id of the requester owning the disassembler.
- `busy`  out  1  high in SEND and DRAIN.
- `done`  out  1  one-cycle pulse on the last beat's handshake.

## Operation
- FSM states: IDLE, SEND, DRAIN. Reset enters IDLE.
- Reset values:
  - `ptr`=0, `beat_cnt`=0, `msg_reg`=0, `src_reg`=0.
  - Outputs: `req_rdy`=0, `dis_req_val`=0, `dis_req_msg`=0, `cur_src`=0, `busy`=0, `done`=0.
- **IDLE**
  - Arbitrate combinationally. The winner is the first index i scanning ptr, ptr+1, …, wrapping mod nreqs, with `req_val[i]`=1.
  - Assert `req_rdy[winner]` only.
  - On that handshake: `msg_reg`←`req_msg[winner]`, `src_reg`←winner, `ptr`←(winner+1) mod nreqs, go to SEND.
  - With no `req_val`: stay in IDLE, `ptr` unchanged.
- **SEND**
  - `dis_req_val`=1, `dis_req_msg`=`msg_reg`.
  - All `req_rdy` are 0.
  - On `dis_req_rdy`: clear `beat_cnt` to 0 and go to DRAIN.
  - Otherwise hold SEND indefinitely, with message stable.
- **DRAIN**
  - A beat is one cycle where `dis_resp_val & dis_resp_rdy` = 1.
  - Each beat increments `beat_cnt`.
  - On the beat where `beat_cnt`==num_beats-1: assert `done` that cycle and go to IDLE.
  - Stalls (`dis_resp_rdy`=0) hold state and count.
- `cur_src`=`src_reg` in SEND and DRAIN. In IDLE it holds the last value (0 after reset).
- `beat_cnt` width is $clog2(num_beats)+1. It never wraps; it is cleared on SEND→DRAIN.
- Beats snooped in IDLE or SEND are ignored and not counted.
- The arbiter grants only in IDLE. Requests raised in SEND/DRAIN wait. Requesters hold `req_val` and `req_msg` until `req_rdy`.
- `nreqs`=1: the arbiter degenerates to always granting index 0, and `ptr` stays 0.

## Timing
- Accept-to-disassembler latency:
  - Requester handshake in cycle N.
  - `dis_req_val` is high from cycle N+1.
  - Earliest DRAIN entry is cycle N+2.
- Minimum turnaround:
  - Last-beat cycle M has `done`=1 and leaves DRAIN.
  - IDLE in cycle M+1 can grant the next requester that same cycle.
  - Its `dis_req_val` is high at M+2.
- Grant fairness: with every requester continuously valid, grants cycle 0,1,…,nreqs-1,0,… with no requester skipped.
- `done` is combinational from `dis_resp_val & dis_resp_rdy & (state==DRAIN) & (beat_cnt==num_beats-1)`.
- Asynchronous reset in any state:
  - Immediately forces IDLE, `ptr`=0, `busy`=0, `dis_req_val`=0 and all `req_rdy`=0.
  - Any in-flight packet is discarded and is not re-sent.
- On the first clock edge after `reset` deasserts, arbitration restarts from index 0.

## Test plan
- **Single packet:** nreqs=2, 16→8, `req_msg[0]`=0xABCD, downstream always ready.
  - `req_rdy[0]` in cycle 0; `dis_req_msg`=0xABCD with `dis_req_val` in cycle 1.
  - Two beats follow; `done` on the 2nd beat; `cur_src`=0 throughout.
- **Simultaneous requests:** `req_msg[0]`=0x1111 and `req_msg[1]`=0x2222 both valid after reset.
  - Requester 0 is served first, then requester 1 immediately after `done`; `cur_src` reads 0 then 1.
- **Round-robin fairness:** nreqs=3, all requesters continuously valid for 6 packets.
  - Grant order is 0,1,2,0,1,2; `ptr` returns to 0.
- **Backpressure:** `dis_req_rdy`=0 for 5 cycles in SEND, then `dis_resp_rdy` toggles 1,0,1.
  - `dis_req_msg` stays stable throughout SEND.
  - `beat_cnt` advances only on handshakes; `done` fires exactly on the 2nd beat; no `req_rdy` while busy.
- **Spurious beat:** pulse `dis_resp_val & dis_resp_rdy` while in IDLE and while in SEND.
  - It is not counted; the subsequent packet still needs 2 beats in DRAIN.
- **Reset mid-DRAIN:** assert `reset` after 1 of 2 beats with requester 1 pending.
  - Outputs return to reset values asynchronously.
  - After release, requester 1 is granted with `ptr` reset to 0.
  - The aborted packet is not replayed.
